// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller bus bundle: pipeline control inputs, the instruction-memory
// req/ack channel and the delivered-instruction outputs.
//   master : the fetch controller (drives imem_req/addr and instr_* outputs)
//   slave  : the environment (pipeline control plus instruction memory)
interface pc_fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              start;
    logic              stall;
    logic              halt;
    logic              branch_taken;
    logic [15:0]       branch_offset;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic [2:0]        state;
    logic              fault;

    modport master (
        input  start, stall, halt, branch_taken, branch_offset, jump, jump_target,
        input  imem_ack, imem_rdata,
        output imem_req, imem_addr, instr_valid, instr, instr_pc, state, fault
    );

    modport slave (
        output start, stall, halt, branch_taken, branch_offset, jump, jump_target,
        output imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, state, fault
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer for a 1024-word instruction window.
// Owns the PC, fetches over a req/ack handshake, delivers instr/instr_pc with a
// one-cycle instr_valid pulse, and applies stall/branch/jump/halt control.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus_io : fetch bus (pc_fetch_ctrl_if.master): control in, imem req/ack,
//            delivered instruction, debug state and sticky fault out
module pc_fetch_ctrl #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h940,
    parameter int unsigned       WIN_SIZE  = 1024
) (
    input  logic             clk,
    input  logic             reset,
    pc_fetch_ctrl_if.master  bus_io
);
    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StIssue = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StHalt  = 3'd3;
    localparam logic [2:0] StFault = 3'd4;

    localparam logic [ADDR_W-1:0] LastAddr = BASE_ADDR + ADDR_W'(WIN_SIZE - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic              fault_q, fault_d;
    logic              pend_redir_q, pend_redir_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              pend_halt_q, pend_halt_d;

    logic              redir_req;
    logic [ADDR_W-1:0] redir_tgt;
    logic              eff_redir;
    logic [ADDR_W-1:0] eff_tgt;
    logic              eff_halt;
    logic [ADDR_W-1:0] pc_inc;

    function automatic logic in_window(input logic [ADDR_W-1:0] a);
        return (a >= BASE_ADDR) && (a <= LastAddr);
    endfunction

    // Jump outranks branch; branch is relative to the last delivered instruction.
    assign redir_req = bus_io.jump | bus_io.branch_taken;
    assign redir_tgt = bus_io.jump ? bus_io.jump_target
                     : instr_pc_q + ADDR_W'(1)
                       + {{(ADDR_W-16){bus_io.branch_offset[15]}}, bus_io.branch_offset};

    // A request arriving on the ack cycle is the latest one, so it beats a pending one.
    assign eff_redir = redir_req | pend_redir_q;
    assign eff_tgt   = redir_req ? redir_tgt : pend_tgt_q;
    assign eff_halt  = bus_io.halt | pend_halt_q;
    assign pc_inc    = (pc_q == LastAddr) ? BASE_ADDR : pc_q + ADDR_W'(1);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = 1'b0;
        fault_d       = fault_q;
        pend_redir_d  = pend_redir_q;
        pend_tgt_d    = pend_tgt_q;
        pend_halt_d   = pend_halt_q;

        case (state_q)
            StIdle: begin
                if (bus_io.start) state_d = StIssue;
            end
            StIssue: begin
                if (bus_io.imem_ack) begin
                    pend_redir_d = 1'b0;
                    pend_halt_d  = 1'b0;
                    // Out-of-window targets latched mid-handshake fault here, once
                    // the outstanding request has completed.
                    if (eff_redir && !in_window(eff_tgt)) begin
                        state_d = StFault;
                        fault_d = 1'b1;
                    end else begin
                        if (eff_redir) begin
                            pc_d = eff_tgt;
                        end else begin
                            instr_d       = bus_io.imem_rdata;
                            instr_pc_d    = pc_q;
                            instr_valid_d = 1'b1;
                            pc_d          = pc_inc;
                        end
                        if (eff_halt)          state_d = StHalt;
                        else if (bus_io.stall) state_d = StWait;
                        else                   state_d = StIssue;
                    end
                end else begin
                    // Request cannot be withdrawn: remember control for the ack cycle.
                    if (redir_req) begin
                        pend_redir_d = 1'b1;
                        pend_tgt_d   = redir_tgt;
                    end
                    if (bus_io.halt) pend_halt_d = 1'b1;
                end
            end
            StWait, StHalt: begin
                if (redir_req && !in_window(redir_tgt)) begin
                    state_d = StFault;
                    fault_d = 1'b1;
                end else begin
                    if (redir_req) pc_d = redir_tgt;
                    if (state_q == StWait) begin
                        if (bus_io.halt)        state_d = StHalt;
                        else if (!bus_io.stall) state_d = StIssue;
                    end else if (bus_io.start) begin
                        state_d = StIssue;
                    end
                end
            end
            StFault: begin
                // Only reset leaves this state.
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            pc_q          <= BASE_ADDR;
            instr_q       <= '0;
            instr_pc_q    <= BASE_ADDR;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            pend_redir_q  <= 1'b0;
            pend_tgt_q    <= '0;
            pend_halt_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
            pend_redir_q  <= pend_redir_d;
            pend_tgt_q    <= pend_tgt_d;
            pend_halt_q   <= pend_halt_d;
        end
    end

    assign bus_io.imem_req    = (state_q == StIssue);
    assign bus_io.imem_addr   = pc_q;
    assign bus_io.instr_valid = instr_valid_q;
    assign bus_io.instr       = instr_q;
    assign bus_io.instr_pc    = instr_pc_q;
    assign bus_io.state       = state_q;
    assign bus_io.fault       = fault_q;
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Instruction-fetch sequencer for the Group 4 MIPS CPU. It owns the program counter for the group's 1024-word instruction window (0x940–0xD3F). It issues word addresses to instruction memory over a req/ack handshake and delivers fetched instructions with their PC. It also applies stall, branch, jump and halt control from the pipeline.

Parameters:
BASE_ADDR, 32'h940, first word address of the window; reset PC.
WIN_SIZE, 1024, window size in words; last valid address = BASE_ADDR+WIN_SIZE-1 (0xD3F).
ADDR_W, 32, width of address/PC paths.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  begin/resume fetching from IDLE or HALT.
stall  in  1  pipeline cannot accept a new instruction.
halt  in  1  stop fetching after the current handshake.
branch_taken  in  1  relative redirect request.
branch_offset  in  16  signed word offset.
jump  in  1  absolute redirect request.
jump_target  in  32  absolute word address.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  32  fetch address (current PC).
imem_ack  in  1  memory returns imem_rdata this cycle.
imem_rdata  in  32  fetched instruction word.
instr_valid  out  1  one-cycle pulse: instr/instr_pc valid.
instr  out  32  delivered instruction.
instr_pc  out  32  address of delivered instruction.
state  out  3  FSM state, for debug.
fault  out  1  sticky out-of-window redirect error.

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-handshake. State=IDLE, pc=BASE_ADDR, imem_req=0, imem_addr=0x940, instr_valid=0, instr=0, instr_pc=0x940, fault=0, pending redirect/halt cleared.
- States (encoding): IDLE=0, ISSUE=1, WAIT=2, HALT=3, FAULT=4.
- imem_addr always equals pc. imem_req=1 only in ISSUE.
- Handshake rules:
  - Once imem_req rises, it and imem_addr stay stable until a cycle with imem_ack=1.
  - imem_ack outside ISSUE is ignored.
  - Ack in the same cycle that req rises is legal, giving 1 instruction/cycle throughput.
- IDLE: start=1 -> ISSUE next cycle.
- ISSUE, ack cycle with no redirect in effect:
  - instr<=imem_rdata, instr_pc<=pc, instr_valid=1 next cycle (single-cycle pulse).
  - pc<=pc+1, except pc==BASE_ADDR+WIN_SIZE-1 -> pc<=BASE_ADDR (wrap 0xD3F->0x940).
  - Next state: HALT if halt or pending halt; else WAIT if stall; else ISSUE.
- ISSUE without ack:
  - Redirect or halt requests are latched as pending (last request wins).
  - stall is ignored because the request cannot be withdrawn.
- Redirect priority: jump > branch_taken.
  - Branch target = instr_pc+1+sext(branch_offset), computed mod 2^32.
  - Jump target = jump_target.
  - Redirect in effect (current or pending) on the ack cycle: fetched word is discarded (no instr_valid), pc<=target, pending cleared.
- WAIT:
  - Redirect: pc<=target immediately.
  - halt -> HALT.
  - stall=0 -> ISSUE.
  - Otherwise remain.
- HALT: imem_req=0, pc held. start -> ISSUE at held pc. Redirects here are applied to pc.
- Window check: any redirect target outside [BASE_ADDR, BASE_ADDR+WIN_SIZE-1] -> FAULT next cycle.
  - fault=1, imem_req=0, no instr_valid, pc unchanged.
  - Only reset exits FAULT.
- Simultaneous events:
  - halt with redirect: redirect updates pc, then HALT.
  - start while already running: ignored.
  - stall together with redirect in WAIT: pc updates, state stays WAIT.

Test Plan:
- Reset, start, ack every cycle -> imem_addr 0x940,0x941,0x942...; instr_valid each cycle, instr_pc trailing by one.
- pc=0xD3F, ack -> instr_pc=0xD3F delivered; next imem_addr=0x940 (wrap).
- Ack delayed 3 cycles with stall=1 raised mid-wait -> req/addr held stable; after ack, state=WAIT, req=0; stall=0 -> ISSUE at pc+1.
- Delivered instr_pc=0x950, branch_taken with offset -4 (0xFFFC) while in ISSUE before ack -> fetched word discarded; next imem_addr=0x94D.
- jump_target=0xD40 -> state=FAULT, fault=1, imem_req=0; start has no effect; reset clears to IDLE, pc=0x940.
- Assert halt during ISSUE with ack pending, then reset mid-ISSUE -> after ack, instruction delivered, state=HALT; reset drops imem_req asynchronously and returns pc=0x940 with no instr_valid.
